// File: rtl/shift_arb_pkg.sv
// rtl/shift_arb_pkg.sv - shared types and constants for the shift arbiter
//
// Purpose: FSM state enumeration and the per-pass shift limit used by
//          shift_arbiter.
// Ports:   none (package).

package shift_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Largest shift one pass of the 3-bit barrel shifter can perform.
  localparam int MAX_STEP = 7;

endpackage

// File: rtl/shift_arbiter_barrel_shifter.sv
// rtl/shift_arbiter_barrel_shifter.sv - combinational logical left barrel shifter
//
// Purpose: one pass of a logical left shift, zero fill, by 0..7 positions.
// Ports:
//   i_data  [WIDTH-1:0]  operand
//   i_shift [2:0]        shift amount for this pass
//   o_data  [WIDTH-1:0]  i_data << i_shift

module barrelShifter #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] i_data,
  input  logic [2:0]       i_shift,
  output logic [WIDTH-1:0] o_data
);

  logic [WIDTH-1:0] w_s1;
  logic [WIDTH-1:0] w_s2;

  // Three log stages: shift by 1, then 2, then 4.
  assign w_s1   = i_shift[0] ? {i_data[WIDTH-2:0], 1'b0} : i_data;
  assign w_s2   = i_shift[1] ? {w_s1[WIDTH-3:0], 2'b00}  : w_s1;
  assign o_data = i_shift[2] ? {w_s2[WIDTH-5:0], 4'b0000} : w_s2;

endmodule

// File: rtl/shift_arbiter.sv
// rtl/shift_arbiter.sv - two-requester arbiter sharing one multi-pass barrel shifter
//
// Purpose: accepts one left-shift operation at a time from two requesters
//          (round-robin on contention), performs it in passes of at most
//          MAX_STEP positions, and holds the result until consumed.
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   reqN_valid/data/amt         operation offered by requester N (N = 0, 1)
//   reqN_ready                  operation of requester N accepted this cycle
//   res_valid/res_ready         result handshake
//   res_data, res_id            shifted result and owning requester
//   busy                        operation in flight (not IDLE)

module shift_arbiter
  import shift_arb_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int AMT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  input  logic [WIDTH-1:0] req0_data,
  input  logic [AMT_W-1:0] req0_amt,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [WIDTH-1:0] req1_data,
  input  logic [AMT_W-1:0] req1_amt,
  output logic             req1_ready,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_data,
  output logic             res_id,
  output logic             busy
);

  state_t           r_state;
  logic [WIDTH-1:0] r_acc;
  logic [AMT_W-1:0] r_rem;
  logic             r_last_grant;
  logic             r_res_id;
  logic             r_res_valid;
  logic             r_busy;

  logic             w_gnt_any;
  logic             w_gnt_id;
  logic [WIDTH-1:0] w_sel_data;
  logic [AMT_W-1:0] w_sel_amt;
  logic [2:0]       w_step;
  logic [AMT_W-1:0] w_rem_next;
  logic [WIDTH-1:0] w_shifted;

  // On contention the requester that was not granted last wins.
  always_comb begin
    w_gnt_any  = req0_valid | req1_valid;
    w_gnt_id   = (req0_valid & req1_valid) ? ~r_last_grant : req1_valid;
    w_sel_data = w_gnt_id ? req1_data : req0_data;
    w_sel_amt  = w_gnt_id ? req1_amt  : req0_amt;
  end

  // rst_n is folded in so ready stays low while reset is held.
  assign req0_ready = rst_n && (r_state == IDLE) && w_gnt_any && !w_gnt_id;
  assign req1_ready = rst_n && (r_state == IDLE) && w_gnt_any &&  w_gnt_id;

  assign w_step     = (r_rem > AMT_W'(MAX_STEP)) ? 3'(MAX_STEP) : r_rem[2:0];
  assign w_rem_next = r_rem - AMT_W'(w_step);

  barrelShifter #(
    .WIDTH (WIDTH)
  ) u_shifter (
    .i_data  (r_acc),
    .i_shift (w_step),
    .o_data  (w_shifted)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_acc        <= '0;
      r_rem        <= '0;
      r_last_grant <= 1'b1;
      r_res_id     <= 1'b0;
      r_res_valid  <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_gnt_any) begin
            r_acc        <= w_sel_data;
            r_rem        <= w_sel_amt;
            r_res_id     <= w_gnt_id;
            r_last_grant <= w_gnt_id;
            r_busy       <= 1'b1;
            r_state      <= SHIFT;
          end
        end
        SHIFT: begin
          // Amount 0 still takes one pass (step 0) before DONE.
          r_acc <= w_shifted;
          r_rem <= w_rem_next;
          if (w_rem_next == '0) begin
            r_res_valid <= 1'b1;
            r_state     <= DONE;
          end
        end
        DONE: begin
          if (res_ready) begin
            r_res_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign res_valid = r_res_valid;
  assign res_data  = r_acc;
  assign res_id    = r_res_id;
  assign busy      = r_busy;

endmodule

// File: tb/tb_shift_arbiter.sv
// tb/tb_shift_arbiter.sv - self-checking bench for shift_arbiter

module tb_shift_arbiter;

  localparam int WIDTH = 8;
  localparam int AMT_W = 4;

  typedef struct {
    logic [WIDTH-1:0] d;
    logic [AMT_W-1:0] a;
  } op_t;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             req0_valid = 1'b0;
  logic [WIDTH-1:0] req0_data = '0;
  logic [AMT_W-1:0] req0_amt = '0;
  logic             req0_ready;
  logic             req1_valid = 1'b0;
  logic [WIDTH-1:0] req1_data = '0;
  logic [AMT_W-1:0] req1_amt = '0;
  logic             req1_ready;
  logic             res_valid;
  logic             res_ready = 1'b0;
  logic [WIDTH-1:0] res_data;
  logic             res_id;
  logic             busy;

  shift_arbiter #(.WIDTH(WIDTH), .AMT_W(AMT_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (req0_valid),
    .req0_data  (req0_data),
    .req0_amt   (req0_amt),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_data  (req1_data),
    .req1_amt   (req1_amt),
    .req1_ready (req1_ready),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res_data   (res_data),
    .res_id     (res_id),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Transaction-level reference: one operation in flight, a countdown of
  // cycles until the result appears, and the arithmetic result itself.
  op_t              q0[$];
  op_t              q1[$];
  bit               m_pending;
  int               m_wait;
  logic [WIDTH-1:0] m_res;
  bit               m_id;
  bit               m_last;
  int               bp_low;
  int               n_results;

  function automatic int passes_for(int amt);
    return (amt == 0) ? 1 : (amt + 6) / 7;
  endfunction

  function automatic logic [WIDTH-1:0] shifted_value(logic [WIDTH-1:0] d, int amt);
    logic [2*WIDTH+15:0] wide;
    wide = {{(WIDTH+16){1'b0}}, d} << amt;
    return wide[WIDTH-1:0];
  endfunction

  task automatic model_reset();
    m_pending = 1'b0;
    m_wait    = 0;
    m_last    = 1'b1;
    q0.delete();
    q1.delete();
  endtask

  task automatic drive_reqs();
    req0_valid = (q0.size() > 0);
    if (req0_valid) begin
      req0_data = q0[0].d;
      req0_amt  = q0[0].a;
    end else begin
      req0_data = WIDTH'($urandom);
      req0_amt  = AMT_W'($urandom);
    end
    req1_valid = (q1.size() > 0);
    if (req1_valid) begin
      req1_data = q1[0].d;
      req1_amt  = q1[0].a;
    end else begin
      req1_data = WIDTH'($urandom);
      req1_amt  = AMT_W'($urandom);
    end
  endtask

  function automatic op_t rand_op();
    op_t o;
    o.d = WIDTH'($urandom);
    o.a = AMT_W'($urandom_range(0, 15));
    return o;
  endfunction

  // Entered at a falling edge: drive, check, advance the model, wait next falling edge.
  task automatic step_cycle(input bit rand_mode);
    bit   exp_rv;
    bit   g_any;
    bit   g_id;
    op_t  op;
    if (rand_mode) begin
      if (q0.size() == 0 && $urandom_range(0, 2) == 0) q0.push_back(rand_op());
      if (q1.size() == 0 && $urandom_range(0, 2) == 0) q1.push_back(rand_op());
    end
    drive_reqs();
    exp_rv = m_pending && (m_wait == 0);
    if (exp_rv && bp_low > 0) begin
      res_ready = 1'b0;
      bp_low--;
    end else if (rand_mode) begin
      res_ready = ($urandom_range(0, 3) != 0);
    end else begin
      res_ready = 1'b1;
    end
    #1;
    g_any = 1'b0;
    g_id  = 1'b0;
    if (!m_pending) begin
      if (req0_valid && req1_valid) begin
        g_any = 1'b1;
        g_id  = ~m_last;
      end else if (req0_valid || req1_valid) begin
        g_any = 1'b1;
        g_id  = req1_valid;
      end
    end
    check_eq("req0_ready", req0_ready, g_any && !g_id);
    check_eq("req1_ready", req1_ready, g_any && g_id);
    check_eq("res_valid", res_valid, exp_rv);
    check_eq("busy", busy, m_pending);
    if (exp_rv) begin
      check_eq("res_data", res_data, m_res);
      check_eq("res_id", res_id, m_id);
    end
    if (exp_rv) begin
      if (res_ready) begin
        m_pending = 1'b0;
        n_results++;
      end
    end else if (m_pending) begin
      m_wait--;
    end else if (g_any) begin
      op = g_id ? q1.pop_front() : q0.pop_front();
      m_pending = 1'b1;
      m_wait    = passes_for(int'(op.a));
      m_res     = shifted_value(op.d, int'(op.a));
      m_id      = g_id;
      m_last    = g_id;
    end
    @(negedge clk);
  endtask

  task automatic run(input int n, input bit rand_mode);
    for (int i = 0; i < n; i++) step_cycle(rand_mode);
  endtask

  task automatic check_reset_outputs();
    check_eq("rst_res_valid", res_valid, 1'b0);
    check_eq("rst_res_data", res_data, '0);
    check_eq("rst_res_id", res_id, 1'b0);
    check_eq("rst_busy", busy, 1'b0);
    check_eq("rst_req0_ready", req0_ready, 1'b0);
    check_eq("rst_req1_ready", req1_ready, 1'b0);
  endtask

  function automatic op_t mk(logic [WIDTH-1:0] d, logic [AMT_W-1:0] a);
    op_t o;
    o.d = d;
    o.a = a;
    return o;
  endfunction

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bp_low    = 0;
    n_results = 0;
    model_reset();

    // Both requesters valid while reset is held: outputs and readies must be 0.
    q0.push_back(mk(8'b1111_1000, 4'd1));
    q1.push_back(mk(8'b0000_0001, 4'd7));
    drive_reqs();
    #2;
    check_reset_outputs();
    @(negedge clk);
    rst_n = 1'b1;

    // Contention from reset: req0 first, then req1, then alternation.
    run(10, 1'b0);
    q0.push_back(mk(8'h33, 4'd2));
    q1.push_back(mk(8'h0F, 4'd3));
    q0.push_back(mk(8'h01, 4'd6));
    q1.push_back(mk(8'h80, 4'd0));
    run(24, 1'b0);

    // Single pass, multi-pass, amount-0 cases.
    q0.push_back(mk(8'b0000_0001, 4'd4));
    run(5, 1'b0);
    q0.push_back(mk(8'b1010_1010, 4'd9));
    run(6, 1'b0);
    q0.push_back(mk(8'b0000_0001, 4'd15));
    run(7, 1'b0);
    q0.push_back(mk(8'b1010_1010, 4'd0));
    run(5, 1'b0);
    q1.push_back(mk(8'h03, 4'd7));
    q1.push_back(mk(8'h03, 4'd8));
    q1.push_back(mk(8'h03, 4'd14));
    run(16, 1'b0);

    // Backpressure: five DONE cycles with res_ready low while both requesters wait.
    bp_low = 5;
    q0.push_back(mk(8'h0F, 4'd3));
    q1.push_back(mk(8'h3C, 4'd2));
    q0.push_back(mk(8'h81, 4'd1));
    run(24, 1'b0);

    // Random traffic with random consumer backpressure, then drain.
    run(3000, 1'b1);
    run(80, 1'b0);

    // Reset in the middle of a 3-pass operation.
    q0.push_back(mk(8'b0000_0001, 4'd15));
    q1.push_back(mk(8'h55, 4'd2));
    run(2, 1'b0);
    rst_n = 1'b0;
    drive_reqs();
    #1;
    check_reset_outputs();
    model_reset();
    drive_reqs();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_eq("rst_hold_res_valid", res_valid, 1'b0);
      check_eq("rst_hold_busy", busy, 1'b0);
    end
    rst_n = 1'b1;
    run(6, 1'b0);
    q0.push_back(mk(8'b1111_1000, 4'd1));
    q1.push_back(mk(8'b0000_0001, 4'd7));
    run(12, 1'b0);

    check_eq("results_seen", (n_results > 20), 1'b1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/shift_arbiter.md
SHIFT_ARBITER -- requirements
Module: shift_arbiter

Interface
REQ-001 Parameter WIDTH, default 8, operand/result width; SHALL equal the barrelShifter data width.
REQ-002 Parameter AMT_W, default 4, requested shift-amount width (amounts 0..15).
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst_n  in  1  asynchronous, active-low reset.
REQ-005 req0_valid / req1_valid  in  1  requester n has an operation pending.
REQ-006 req0_data / req1_data  in  WIDTH  operand from requester n.
REQ-007 req0_amt / req1_amt  in  AMT_W  left-shift amount from requester n.
REQ-008 req0_ready / req1_ready  out  1  operation of requester n accepted this cycle.
REQ-009 res_valid  out  1  result available.
REQ-010 res_ready  in  1  consumer takes result.
REQ-011 res_data  out  WIDTH  shifted result.
REQ-012 res_id  out  1  requester index owning res_data.
REQ-013 busy  out  1  high in any state other than IDLE.

Function
REQ-014 The block SHALL share one barrelShifter instance (logical left shift, zero fill, 0..7 per pass) between two requesters.
REQ-015 FSM states SHALL be IDLE, SHIFT, DONE.
REQ-016 In IDLE, grant SHALL be combinational: only one valid -> that requester; both valid -> the requester not granted last; neither -> no grant.
REQ-017 reqN_ready SHALL be high only in IDLE, only for the granted requester; a transfer occurs when valid and ready are both high.
REQ-018 On transfer the block SHALL latch data into acc, amount into rem, index into res_id, update last_grant, and enter SHIFT.
REQ-019 In SHIFT, each cycle: step = min(rem,7); acc <= shifter(acc, step); rem <= rem - step.
REQ-020 SHIFT SHALL exit to DONE in the cycle where rem - step == 0; amount 0 takes exactly one pass with step 0.
REQ-021 Pass count SHALL be 1 for amount 0, else ceil(amount/7): amt 7 -> 1, 8 -> 2, 14 -> 2, 15 -> 3.
REQ-022 Latency: transfer at edge k -> res_valid high after edge k+passes.
REQ-023 Amounts >= WIDTH SHALL yield all-zero res_data.
REQ-024 In DONE, res_valid=1 and res_data/res_id SHALL hold stable until res_ready; on res_valid && res_ready -> IDLE.
REQ-025 No request SHALL be accepted in SHIFT or DONE; requesters hold valid/data/amt until ready.
REQ-026 The earliest next acceptance SHALL be the cycle after the result handshake (no overlap).
REQ-027 res_ready outside DONE SHALL be ignored.

Reset
REQ-028 rst_n low SHALL immediately force IDLE, res_valid=0, res_data=0, res_id=0, busy=0, acc=0, rem=0, last_grant=1 (req0 wins first contention).
REQ-029 Reset during SHIFT or DONE SHALL discard the in-flight operation with no result produced.
REQ-030 reqN_ready SHALL be 0 while rst_n is low.

Structure
REQ-031 Package shift_arb_pkg SHALL hold the state enumeration (IDLE, SHIFT, DONE) and constant MAX_STEP=7.
REQ-032 The single sub-module SHALL be barrelShifter (data WIDTH, shift 3 bits) fed by acc and step; all sequencing stays in shift_arbiter.

Verification
REQ-033 req0 only: data 00000001, amt 4 -> after 1 pass res_data 00010000, res_id 0, req0_ready high exactly one cycle.
REQ-034 Multi-pass: data 10101010, amt 9 -> 2 passes (7,2), res_data 00000000; data 00000001, amt 15 -> 3 passes, res_data 00000000, busy high 4 cycles including DONE.
REQ-035 Contention: both valid from reset (req0 11111000 amt 1, req1 00000001 amt 7) -> req0 served first (11110000, id 0), then req1 (10000000, id 1); repeated contention alternates.
REQ-036 Backpressure: res_ready low 5 cycles in DONE -> res_data/res_id stable, both readies low; result transferred on the first res_ready high, acceptance the following cycle.
REQ-037 Amount 0: data 10101010, amt 0 -> exactly one SHIFT cycle, res_data 10101010.
REQ-038 Reset mid-SHIFT with amt 15 -> all outputs zero immediately; no res_valid after release; next request behaves as from reset.
